// File: rtl/conv3x3_window_gen.sv
// conv3x3_window_gen
//   Streaming 3x3 window generator. Converts a raster-order pixel stream into
//   packed 3x3 windows ("valid" convolution, no padding): one window per
//   accepted pixel whose position is row >= 2 and col >= 2, so each frame
//   yields (IMG_W-2)x(IMG_H-2) windows.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   pix_valid  source has a pixel
//   pix_ready  block accepts a pixel this cycle (combinational from win_ready)
//   pix_data   pixel value, raster order
//   pix_sof    start of frame, meaningful only on an accepted pixel
//   win_valid  win_data holds a valid window
//   win_ready  downstream consumes the window
//   win_data   packed [2:0][2:0][DATA_W-1:0]; [r][c] at (r*3+c)*DATA_W;
//              r=0 oldest row, c=0 oldest column
//   win_last   set with the final window of a frame
module conv3x3_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [DATA_W-1:0]     pix_data,
  input  logic                  pix_sof,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [9*DATA_W-1:0]   win_data,
  output logic                  win_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]                 r_col;
  logic [RW-1:0]                 r_row;
  logic [DATA_W-1:0]             r_lb0 [IMG_W];   // row-1
  logic [DATA_W-1:0]             r_lb1 [IMG_W];   // row-2
  logic [2:0][2:0][DATA_W-1:0]   r_win;
  logic                          r_win_valid;
  logic                          r_win_last;

  logic                          w_acc;
  logic [CW-1:0]                 w_col;
  logic [RW-1:0]                 w_row;
  logic                          w_col_end;
  logic                          w_row_end;
  logic                          w_emit;
  logic [DATA_W-1:0]             w_a;
  logic [DATA_W-1:0]             w_b;

  // Accepting a pixel overwrites the window register, so only accept once the
  // current window has been taken (or there is none).
  assign pix_ready = !r_win_valid || win_ready;
  assign w_acc     = pix_valid && pix_ready;

  // SOF forces the pixel to (0,0), which discards any partial frame.
  assign w_col     = pix_sof ? '0 : r_col;
  assign w_row     = pix_sof ? '0 : r_row;
  assign w_col_end = (w_col == CW'(IMG_W-1));
  assign w_row_end = (w_row == RW'(IMG_H-1));
  assign w_emit    = (w_row >= RW'(2)) && (w_col >= CW'(2));

  assign w_a = r_lb1[w_col];
  assign w_b = r_lb0[w_col];

  // Raster position counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      r_col <= w_col_end ? '0 : w_col + 1'b1;
      r_row <= w_col_end ? (w_row_end ? '0 : w_row + 1'b1) : w_row;
    end
  end

  // Line buffers: plain RAM, never cleared. Reads above see the old contents
  // (read-before-write), so lb1 takes the row-1 value before lb0 is refreshed.
  always_ff @(posedge clk) begin
    if (rst_n && w_acc) begin
      r_lb1[w_col] <= w_b;
      r_lb0[w_col] <= pix_data;
    end
  end

  // Window shift register and output qualifiers. The shift register moves on
  // every accept, emitting or not, so after a column wrap the columns refill
  // from the current row triplet before the next emit at col 2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_win       <= '0;
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
    end else if (w_acc) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= w_a;
      r_win[1][2] <= w_b;
      r_win[2][2] <= pix_data;
      r_win_valid <= w_emit;
      r_win_last  <= w_emit && w_row_end && w_col_end;
    end else if (win_ready) begin
      r_win_valid <= 1'b0;
    end
  end

  assign win_valid = r_win_valid;
  assign win_last  = r_win_last;
  assign win_data  = r_win;

endmodule

// File: tb/tb_conv3x3_window_gen.sv
module tb_conv3x3_window_gen;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pix_valid;
  logic          pix_ready;
  logic [DW-1:0] pix_data;
  logic          pix_sof;
  logic          win_valid;
  logic          win_ready;
  logic [9*DW-1:0] win_data;
  logic          win_last;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  conv3x3_window_gen #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_sof(pix_sof), .win_valid(win_valid),
    .win_ready(win_ready), .win_data(win_data), .win_last(win_last)
  );

  // Hand-computed 4x4 windows, element order r*3+c (r=0 oldest row).
  int W [4][9] = '{
    '{0, 1, 2,  4,  5,  6,  8,  9, 10},
    '{1, 2, 3,  5,  6,  7,  9, 10, 11},
    '{4, 5, 6,  8,  9, 10, 12, 13, 14},
    '{5, 6, 7,  9, 10, 11, 13, 14, 15}
  };
  int C2 [4] = '{10, 11, 14, 15};

  function automatic logic [9*DW-1:0] exp_win(input int k, input int off);
    logic [9*DW-1:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) w[i*DW +: DW] = DW'(W[k][i] + off);
    return w;
  endfunction

  // Monitor: accepted pixels and consumed windows (with first-seen cycle).
  int cyc = 0;
  int first_c = 0;
  bit held = 0;
  int acc_c[$];
  logic [DW-1:0] acc_d[$];
  logic [9*DW-1:0] wd_q[$];
  logic wl_q[$];
  int wc_q[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_n && pix_valid && pix_ready) begin
      acc_d.push_back(pix_data);
      acc_c.push_back(cyc);
    end
    if (rst_n && win_valid) begin
      if (!held) first_c = cyc;
      held = !win_ready;
      if (win_ready) begin
        wd_q.push_back(win_data);
        wl_q.push_back(win_last);
        wc_q.push_back(first_c);
      end
    end else begin
      held = 0;
    end
  end

  task automatic clear_q();
    acc_c.delete(); acc_d.delete(); wd_q.delete(); wl_q.delete(); wc_q.delete();
  endtask

  // Sends n pixels off+i, SOF on the first; optional one-cycle bubble after each.
  task automatic send(input int n, input int off, input bit bub, output bit to);
    int g;
    bit a;
    to = 0;
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_data  = DW'(off + i);
      pix_sof   = (i == 0);
      g = 0;
      a = 0;
      do begin
        @(negedge clk); a = pix_ready;
        @(posedge clk); #1;
        g++;
      end while (!a && g < 100);
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      if (!a) begin to = 1; i = n; end
      else if (bub) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pix_valid = 1'b0; pix_data = '0; pix_sof = 1'b0; win_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid got=%b exp=0", win_valid); end
    checks++; if (win_last !== 1'b0) begin errors++; $display("FAIL reset_win_last got=%b exp=0", win_last); end
    checks++; if (win_data !== '0) begin errors++; $display("FAIL reset_win_data got=%h exp=0", win_data); end
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL reset_pix_ready got=%b exp=1", pix_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stream(input string nm, input bit bub);
    bit to;
    clear_q();
    send(16, 0, bub, to);
    drain();
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL %s_timeout got=%b exp=0", nm, to); end
    checks++; if (wd_q.size() != 4) begin errors++; $display("FAIL %s_count got=%0d exp=4", nm, wd_q.size()); end
    for (int k = 0; k < 4 && k < wd_q.size(); k++) begin
      checks++;
      if (wd_q[k] !== exp_win(k, 0)) begin errors++; $display("FAIL %s_data[%0d] got=%h exp=%h", nm, k, wd_q[k], exp_win(k, 0)); end
      checks++;
      if (wl_q[k] !== (k == 3)) begin errors++; $display("FAIL %s_last[%0d] got=%b exp=%b", nm, k, wl_q[k], (k == 3)); end
      checks++;
      if (C2[k] >= acc_c.size() || wc_q[k] != acc_c[C2[k]] + 1) begin
        errors++; $display("FAIL %s_latency[%0d] win_cyc=%0d exp=accept+1", nm, k, wc_q[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    bit seen;
    clear_q();
    fork
      send(16, 0, 1'b0, to);
      begin
        seen = 0;
        for (int g = 0; g < 100 && !seen; g++) begin
          @(posedge clk); #1;
          seen = win_valid;
        end
        win_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL bp_pix_ready[%0d] got=%b exp=0", j, pix_ready); end
          checks++; if (win_data !== exp_win(0, 0)) begin errors++; $display("FAIL bp_hold[%0d] got=%h exp=%h", j, win_data, exp_win(0, 0)); end
          @(posedge clk); #1;
        end
        win_ready = 1'b1;
      end
    join
    drain();
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL bp_first_window got=%b exp=1", seen); end
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout got=%b exp=0", to); end
    checks++; if (wd_q.size() != 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", wd_q.size()); end
    for (int k = 0; k < 4 && k < wd_q.size(); k++) begin
      checks++;
      if (wd_q[k] !== exp_win(k, 0)) begin errors++; $display("FAIL bp_data[%0d] got=%h exp=%h", k, wd_q[k], exp_win(k, 0)); end
    end
  endtask

  task automatic test_back_to_back();
    bit to1, to2;
    clear_q();
    send(16, 0, 1'b0, to1);
    send(16, 100, 1'b0, to2);
    drain();
    checks++; if ((to1 | to2) !== 1'b0) begin errors++; $display("FAIL b2b_timeout got=%b exp=0", to1 | to2); end
    checks++; if (wd_q.size() != 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", wd_q.size()); end
    for (int k = 0; k < 8 && k < wd_q.size(); k++) begin
      checks++;
      if (wd_q[k] !== exp_win(k % 4, (k < 4) ? 0 : 100)) begin
        errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, wd_q[k], exp_win(k % 4, (k < 4) ? 0 : 100));
      end
      checks++;
      if (wl_q[k] !== (k == 3 || k == 7)) begin errors++; $display("FAIL b2b_last[%0d] got=%b", k, wl_q[k]); end
    end
  endtask

  task automatic test_resync();
    bit to1, to2;
    clear_q();
    send(6, 0, 1'b0, to1);
    send(16, 0, 1'b0, to2);
    drain();
    checks++; if ((to1 | to2) !== 1'b0) begin errors++; $display("FAIL resync_timeout got=%b exp=0", to1 | to2); end
    checks++; if (wd_q.size() != 4) begin errors++; $display("FAIL resync_count got=%0d exp=4", wd_q.size()); end
    for (int k = 0; k < 4 && k < wd_q.size(); k++) begin
      checks++;
      if (wd_q[k] !== exp_win(k, 0)) begin errors++; $display("FAIL resync_data[%0d] got=%h exp=%h", k, wd_q[k], exp_win(k, 0)); end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    send(11, 0, 1'b0, to);
    checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got=%b exp=1", win_valid); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL rmid_win_valid got=%b exp=0", win_valid); end
    checks++; if (win_last !== 1'b0) begin errors++; $display("FAIL rmid_win_last got=%b exp=0", win_last); end
    checks++; if (win_data !== '0) begin errors++; $display("FAIL rmid_win_data got=%h exp=0", win_data); end
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL rmid_pix_ready got=%b exp=1", pix_ready); end
    test_stream("rmid", 1'b0);
  endtask

  initial begin
    test_reset();
    test_stream("stream", 1'b0);
    test_backpressure();
    test_stream("bubbles", 1'b1);
    test_back_to_back();
    test_resync();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
